// File: rtl/puf_readout_serializer.sv
// puf_readout_serializer: captures a registered PUF response on the rising
// edge of DONE and streams it MSB byte first over a byte valid/ready port.
//
// Ports:
//   CLK          system clock, all state on the rising edge
//   RESET        asynchronous reset, active high
//   DONE         controller done level; a rising edge requests a capture
//   PUF_OUT_REG  response word, stable while DONE is high
//   TX_READY     downstream accepts TX_DATA this cycle
//   CLR_OVR      synchronous clear of OVERRUN
//   TX_DATA      byte on offer (zero while idle)
//   TX_VALID     TX_DATA is valid
//   BUSY         high from capture until the final byte is accepted
//   OVERRUN      sticky: a capture request arrived while not idle
//   WORD_CNT     captured word count, wraps 255 -> 0
//
// Parameters:
//   DATA_W       captured word width, multiple of 8, 8..256
//   APPEND_CHK   1: append an XOR-of-data-bytes checksum byte after the data

module puf_readout_serializer #(
    parameter int DATA_W     = 128,
    parameter bit APPEND_CHK = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DONE,
    input  logic [DATA_W-1:0] PUF_OUT_REG,
    input  logic              TX_READY,
    input  logic              CLR_OVR,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    output logic              BUSY,
    output logic              OVERRUN,
    output logic [7:0]        WORD_CNT
);

    localparam int NBYTES = DATA_W / 8;
    // A one-byte word still needs a 1-bit index to keep the vector legal.
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CHK
    } state_t;

    state_t            state;
    state_t            state_n;

    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_n;
    logic [DATA_W-1:0] shifted;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_n;
    logic [7:0]        chk_q;
    logic [7:0]        chk_n;
    logic              done_d;

    logic [7:0]        data_n;
    logic              valid_n;
    logic              busy_n;
    logic              ovr_n;
    logic [7:0]        cnt_n;

    logic              rise;
    logic              xfer;
    logic              last;

    assign rise    = DONE & ~done_d;
    assign xfer    = TX_VALID & TX_READY;
    assign last    = (idx_q == LAST_IDX);
    assign shifted = shift_q << 8;

    // State and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            chk_q    <= '0;
            done_d   <= 1'b0;
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            OVERRUN  <= 1'b0;
            WORD_CNT <= '0;
        end else begin
            state    <= state_n;
            shift_q  <= shift_n;
            idx_q    <= idx_n;
            chk_q    <= chk_n;
            done_d   <= DONE;
            TX_DATA  <= data_n;
            TX_VALID <= valid_n;
            BUSY     <= busy_n;
            OVERRUN  <= ovr_n;
            WORD_CNT <= cnt_n;
        end
    end

    // Next state and next output values
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        idx_n   = idx_q;
        chk_n   = chk_q;
        data_n  = TX_DATA;
        valid_n = TX_VALID;
        busy_n  = BUSY;
        ovr_n   = OVERRUN;
        cnt_n   = WORD_CNT;

        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n = SEND;
                    shift_n = PUF_OUT_REG;
                    idx_n   = '0;
                    chk_n   = '0;
                    cnt_n   = WORD_CNT + 8'd1;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    data_n  = PUF_OUT_REG[DATA_W-1 -: 8];
                end
            end

            SEND: begin
                if (xfer) begin
                    chk_n   = chk_q ^ TX_DATA;
                    shift_n = shifted;
                    idx_n   = idx_q + 1'b1;
                    if (!last) begin
                        data_n = shifted[DATA_W-1 -: 8];
                    end else if (APPEND_CHK) begin
                        // Checksum must include the byte leaving now.
                        state_n = CHK;
                        data_n  = chk_q ^ TX_DATA;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        data_n  = '0;
                    end
                end
            end

            CHK: begin
                if (xfer) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    data_n  = '0;
                end
            end

            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                data_n  = '0;
            end
        endcase

        // Set after clear so a simultaneous drop keeps the flag high.
        if (CLR_OVR) begin
            ovr_n = 1'b0;
        end
        if (rise && (state != IDLE)) begin
            ovr_n = 1'b1;
        end
    end

endmodule
